// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared constants and FSM encoding for the datamem arbiter
package datamem_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 16;
   localparam int MEM_DEPTH = 64;

   // 2'd3 is unused; the arbiter falls back to IDLE if it is ever reached
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/datamem_arbiter_rr_pick.sv
// rtl/datamem_arbiter_rr_pick.sv - combinational round-robin winner select
// Scans ptr+1, ptr+2, ... mod N_REQ and reports the first requester found.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [ID_W-1:0]  winner_o,
   output logic             any_req_o
);

   logic found;

   always_comb begin
      winner_o  = '0;
      found     = 1'b0;
      any_req_o = |req_i;
      for (int i = 1; i <= N_REQ; i++) begin
         int idx;
         idx = (int'(ptr_i) + i) % N_REQ;
         if (!found && req_i[idx]) begin
            found    = 1'b1;
            winner_o = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - round-robin arbiter in front of the single-port datamem
// One access per IDLE/GRANT/DONE pass; the ack and err pulses are driven only in DONE.
module datamem_arbiter
   import datamem_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ-1:0]        we_i,
   input  logic [N_REQ*ADDR_W-1:0] addr_i,
   input  logic [N_REQ*DATA_W-1:0] wdata_i,
   output logic [N_REQ-1:0]        ack_o,
   output logic [N_REQ-1:0]        err_o,
   output logic [DATA_W-1:0]       rdata_o,
   output logic                    busy_o,
   output logic                    mem_we_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic [DATA_W-1:0]       mem_wdata_o,
   input  logic [DATA_W-1:0]       mem_rdata_i
);

   localparam int ID_W = $clog2(N_REQ);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, id_q, winner;
   logic              any_req, we_q, in_range;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   assign in_range = (addr_q < ADDR_W'(MEM_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_d = ST_GRANT;
         ST_GRANT: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Reset clears the latched request so the memory pins go quiet immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= ID_W'(N_REQ - 1);
         id_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state_q == ST_IDLE && any_req) begin
            ptr_q   <= winner;
            id_q    <= winner;
            we_q    <= we_i[winner];
            addr_q  <= addr_i[int'(winner)*ADDR_W +: ADDR_W];
            wdata_q <= wdata_i[int'(winner)*DATA_W +: DATA_W];
         end
         if (state_q == ST_GRANT && !we_q) begin
            rdata_q <= in_range ? mem_rdata_i : '0;
         end
      end
   end

   always_comb begin
      ack_o    = '0;
      err_o    = '0;
      mem_we_o = 1'b0;
      busy_o   = 1'b0;
      case (state_q)
         ST_GRANT: begin
            busy_o   = 1'b1;
            mem_we_o = we_q & in_range;
         end
         ST_DONE: begin
            busy_o      = 1'b1;
            ack_o[id_q] = 1'b1;
            err_o[id_q] = !in_range;
         end
         default: ;
      endcase
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;

endmodule
